// File: rtl/tfc_pkg.sv
// Shared TFC definitions: command bit positions, orbit length and the
// calibration sequencer state encoding.
package tfc_pkg;

  localparam int unsigned TFC_BXRST  = 0;
  localparam int unsigned TFC_FERST  = 1;
  localparam int unsigned TFC_HEADER = 2;
  localparam int unsigned TFC_CALIB  = 3;
  localparam int unsigned TFC_NZS    = 4;
  localparam int unsigned TFC_SNAP   = 5;
  localparam int unsigned TFC_SYNCH  = 6;
  localparam int unsigned TFC_BXVETO = 7;

  localparam int unsigned BX_MAX_DEF    = 3563;
  localparam int unsigned CAL_DLY_WIDTH = 8;

  typedef enum logic [1:0] {
    CAL_IDLE = 2'd0,
    CAL_WAIT = 2'd1,
    CAL_FIRE = 2'd2
  } cal_state_e;

endpackage

// File: rtl/tfc_calib_seq.sv
// Calibration sequencer: delays an accepted Calib command by a latched
// number of cycles and emits a single-cycle pulse; FEReset aborts it.
module tfc_calib_seq
  import tfc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     calib_i,
  input  logic                     abort_i,
  input  logic [CAL_DLY_WIDTH-1:0] cal_delay_i,
  output logic                     pulse_o,
  output logic                     busy_o,
  output logic                     overrun_evt_c
);

  cal_state_e               state_q;
  logic [CAL_DLY_WIDTH-1:0] cnt_q;

  // A Calib is only dropped in WAIT; an abort in the same word masks it.
  assign overrun_evt_c = calib_i && !abort_i && (state_q == CAL_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CAL_IDLE;
      cnt_q   <= '0;
      pulse_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      pulse_o <= 1'b0;
      busy_o  <= 1'b1;
      if (abort_i) begin
        state_q <= CAL_IDLE;
        cnt_q   <= '0;
        busy_o  <= 1'b0;
      end else begin
        case (state_q)
          // FIRE accepts a new command exactly like IDLE for back-to-back use.
          CAL_IDLE, CAL_FIRE: begin
            if (calib_i) begin
              if (cal_delay_i == CAL_DLY_WIDTH'(0)) begin
                state_q <= CAL_FIRE;
                pulse_o <= 1'b1;
              end else begin
                state_q <= CAL_WAIT;
                cnt_q   <= cal_delay_i;
              end
            end else begin
              state_q <= CAL_IDLE;
              busy_o  <= 1'b0;
            end
          end
          CAL_WAIT: begin
            if (cnt_q == CAL_DLY_WIDTH'(1)) begin
              state_q <= CAL_FIRE;
              pulse_o <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CAL_DLY_WIDTH'(1);
            end
          end
          default: begin
            state_q <= CAL_IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/tfc_cmd_decoder.sv
// TFC command decoder: registered command strobes, local BX counter with
// orbit check, FE reset stretcher and calibration sequencing.
module tfc_cmd_decoder
  import tfc_pkg::*;
#(
  parameter int unsigned TFC_WIDTH  = 8,
  parameter int unsigned BX_MAX     = BX_MAX_DEF,
  parameter int unsigned BXID_WIDTH = 12,
  parameter int unsigned FE_RST_LEN = 4
) (
  input  logic                     main_clk,
  input  logic                     rst_n,
  input  logic [TFC_WIDTH-1:0]     tfc_in,
  input  logic [CAL_DLY_WIDTH-1:0] cal_delay,
  input  logic                     err_clr,
  output logic [BXID_WIDTH-1:0]    bxid,
  output logic                     bx_reset_o,
  output logic                     fe_reset_o,
  output logic                     header_o,
  output logic                     nzs_o,
  output logic                     snapshot_o,
  output logic                     sync_o,
  output logic                     bx_veto_o,
  output logic                     calib_pulse,
  output logic                     calib_busy,
  output logic                     sync_err,
  output logic                     calib_overrun
);

  localparam int unsigned FE_CNT_W = $clog2(FE_RST_LEN + 1);

  logic                  bx_rst;
  logic                  fe_rst;
  logic                  ovr_evt;
  logic [BXID_WIDTH-1:0] bxid_q, bxid_d;
  logic                  first_seen_q, first_seen_d;
  logic                  sync_err_q, sync_err_d;
  logic                  overrun_q, overrun_d;
  logic [FE_CNT_W-1:0]   fe_cnt_q, fe_cnt_d;
  logic                  fe_q;
  logic [6:0]            strb_q;

  assign bx_rst = tfc_in[TFC_BXRST];
  assign fe_rst = tfc_in[TFC_FERST];

  tfc_calib_seq u_calib_seq (
    .clk           (main_clk),
    .rst_n         (rst_n),
    .calib_i       (tfc_in[TFC_CALIB]),
    .abort_i       (fe_rst),
    .cal_delay_i   (cal_delay),
    .pulse_o       (calib_pulse),
    .busy_o        (calib_busy),
    .overrun_evt_c (ovr_evt)
  );

  // Next-state for counter, orbit check, sticky flags and FE stretcher.
  always_comb begin
    bxid_d       = bxid_q + BXID_WIDTH'(1);
    first_seen_d = first_seen_q;
    sync_err_d   = sync_err_q & ~err_clr;
    overrun_d    = (overrun_q & ~err_clr) | ovr_evt;
    fe_cnt_d     = '0;
    if (bxid_q == BXID_WIDTH'(BX_MAX)) bxid_d = '0;
    if (bx_rst) begin
      bxid_d       = '0;
      first_seen_d = 1'b1;
      if (first_seen_q && (bxid_q != BXID_WIDTH'(BX_MAX))) sync_err_d = 1'b1;
    end
    if (fe_rst) fe_cnt_d = FE_CNT_W'(FE_RST_LEN);
    else if (fe_cnt_q != '0) fe_cnt_d = fe_cnt_q - FE_CNT_W'(1);
  end

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      bxid_q       <= '0;
      first_seen_q <= 1'b0;
      sync_err_q   <= 1'b0;
      overrun_q    <= 1'b0;
      fe_cnt_q     <= '0;
      fe_q         <= 1'b0;
      strb_q       <= '0;
    end else begin
      bxid_q       <= bxid_d;
      first_seen_q <= first_seen_d;
      sync_err_q   <= sync_err_d;
      overrun_q    <= overrun_d;
      fe_cnt_q     <= fe_cnt_d;
      fe_q         <= (fe_cnt_d != '0);
      strb_q       <= {tfc_in[TFC_BXVETO], tfc_in[TFC_SYNCH], tfc_in[TFC_SNAP],
                       tfc_in[TFC_NZS], tfc_in[TFC_HEADER], 1'b0, bx_rst};
    end
  end

  assign bxid          = bxid_q;
  assign bx_reset_o    = strb_q[0];
  assign header_o      = strb_q[2];
  assign nzs_o         = strb_q[3];
  assign snapshot_o    = strb_q[4];
  assign sync_o        = strb_q[5];
  assign bx_veto_o     = strb_q[6];
  assign fe_reset_o    = fe_q;
  assign sync_err      = sync_err_q;
  assign calib_overrun = overrun_q;

  logic unused_ok;
  assign unused_ok = strb_q[1];

endmodule

// File: tb/tb_tfc_cmd_decoder.sv
// Directed self-checking bench for tfc_cmd_decoder.
`timescale 1ns/1ps
module tb_tfc_cmd_decoder;

  localparam logic [7:0] W_BXR  = 8'h01;
  localparam logic [7:0] W_FER  = 8'h02;
  localparam logic [7:0] W_HDR  = 8'h04;
  localparam logic [7:0] W_CAL  = 8'h08;
  localparam logic [7:0] W_NZS  = 8'h10;
  localparam logic [7:0] W_SNP  = 8'h20;
  localparam logic [7:0] W_SYN  = 8'h40;
  localparam logic [7:0] W_VETO = 8'h80;

  logic        main_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tfc_in;
  logic [7:0]  cal_delay;
  logic        err_clr;
  logic [11:0] bxid;
  logic        bx_reset_o, fe_reset_o, header_o, nzs_o, snapshot_o, sync_o, bx_veto_o;
  logic        calib_pulse, calib_busy, sync_err, calib_overrun;

  int errors = 0;
  int checks = 0;

  logic [4:0] strb;
  logic [5:0] misc;
  assign strb = {bx_veto_o, sync_o, snapshot_o, nzs_o, header_o};
  assign misc = {bx_reset_o, fe_reset_o, calib_pulse, calib_busy, sync_err, calib_overrun};

  tfc_cmd_decoder dut (
    .main_clk      (main_clk),
    .rst_n         (rst_n),
    .tfc_in        (tfc_in),
    .cal_delay     (cal_delay),
    .err_clr       (err_clr),
    .bxid          (bxid),
    .bx_reset_o    (bx_reset_o),
    .fe_reset_o    (fe_reset_o),
    .header_o      (header_o),
    .nzs_o         (nzs_o),
    .snapshot_o    (snapshot_o),
    .sync_o        (sync_o),
    .bx_veto_o     (bx_veto_o),
    .calib_pulse   (calib_pulse),
    .calib_busy    (calib_busy),
    .sync_err      (sync_err),
    .calib_overrun (calib_overrun)
  );

  always #5 main_clk = ~main_clk;

  task automatic tick();
    @(posedge main_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tfc_in = '0; cal_delay = '0; err_clr = 1'b0;
    repeat (3) tick();
    checks++;
    if (bxid !== 12'd0) begin errors++; $display("FAIL reset_bxid: got %0d expected 0", bxid); end
    checks++;
    if (strb !== 5'd0) begin errors++; $display("FAIL reset_strb: got %b expected 00000", strb); end
    checks++;
    if (misc !== 6'd0) begin errors++; $display("FAIL reset_misc: got %b expected 000000", misc); end
    rst_n = 1'b1;
  endtask

  task automatic test_bx_count();
    int bad = 0;
    checks++;
    if (bxid !== 12'd0) begin errors++; $display("FAIL count_start: got %0d expected 0", bxid); end
    for (int i = 1; i <= 3565; i++) begin
      tick();
      checks++;
      if (bxid !== 12'(i % 3564)) begin
        errors++;
        if (bad < 5) $display("FAIL count_bxid[%0d]: got %0d expected %0d", i, bxid, i % 3564);
        bad++;
      end
    end
    checks++;
    if ({strb, misc} !== 11'd0) begin errors++; $display("FAIL count_quiet: got %b expected 0", {strb, misc}); end
  endtask

  task automatic test_bx_sync();
    tfc_in = W_BXR; tick(); tfc_in = '0;
    checks++;
    if ({bxid, bx_reset_o, sync_err} !== {12'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sync_first: bxid=%0d bxr=%b err=%b expected 0 1 0", bxid, bx_reset_o, sync_err);
    end
    for (int n = 0; n < 2; n++) begin
      repeat (3563) tick();
      checks++;
      if (bxid !== 12'd3563) begin errors++; $display("FAIL sync_orbit_end: got %0d expected 3563", bxid); end
      tfc_in = W_BXR; tick(); tfc_in = '0;
      checks++;
      if ({bxid, sync_err} !== {12'd0, 1'b0}) begin
        errors++; $display("FAIL sync_orbit_ok: bxid=%0d err=%b expected 0 0", bxid, sync_err);
      end
    end
    repeat (100) tick();
    checks++;
    if (bxid !== 12'd100) begin errors++; $display("FAIL sync_bx100: got %0d expected 100", bxid); end
    tfc_in = W_BXR; tick(); tfc_in = '0;
    checks++;
    if ({bxid, sync_err} !== {12'd0, 1'b1}) begin
      errors++; $display("FAIL sync_bad: bxid=%0d err=%b expected 0 1", bxid, sync_err);
    end
    tick();
    err_clr = 1'b1; tfc_in = W_BXR; tick(); tfc_in = '0;
    checks++;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_set_wins: got %b expected 1", sync_err); end
    tick(); err_clr = 1'b0;
    checks++;
    if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_clr: got %b expected 0", sync_err); end
    tick();
    checks++;
    if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_stays_clr: got %b expected 0", sync_err); end
  endtask

  task automatic test_strobes();
    logic [7:0] words [6];
    logic [4:0] exps  [6];
    words = '{W_HDR, W_NZS, W_SNP, W_SYN, W_VETO, 8'hF4};
    exps  = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd31};
    for (int i = 0; i < 6; i++) begin
      tfc_in = words[i]; tick(); tfc_in = '0;
      checks++;
      if (strb !== exps[i] || misc !== 6'd0) begin
        errors++; $display("FAIL strobe[%0d]: strb=%b misc=%b expected %b 000000", i, strb, misc, exps[i]);
      end
      tick();
      checks++;
      if (strb !== 5'd0) begin errors++; $display("FAIL strobe_clear[%0d]: got %b expected 00000", i, strb); end
    end
  endtask

  task automatic test_calib_d0();
    cal_delay = 8'd0; tfc_in = W_CAL; tick(); tfc_in = '0;
    checks++;
    if ({calib_pulse, calib_busy} !== 2'b11) begin
      errors++; $display("FAIL cal0_fire: pulse,busy=%b expected 11", {calib_pulse, calib_busy});
    end
    tick();
    checks++;
    if ({calib_pulse, calib_busy} !== 2'b00) begin
      errors++; $display("FAIL cal0_idle: pulse,busy=%b expected 00", {calib_pulse, calib_busy});
    end
  endtask

  task automatic test_calib_d5();
    cal_delay = 8'd5; tfc_in = W_CAL; tick(); tfc_in = '0;
    for (int j = 1; j <= 8; j++) begin
      checks++;
      if ({calib_pulse, calib_busy} !== {1'(j == 6), 1'(j <= 6)}) begin
        errors++; $display("FAIL cal5[k+%0d]: pulse,busy=%b expected %b", j,
                           {calib_pulse, calib_busy}, {1'(j == 6), 1'(j <= 6)});
      end
      tick();
    end
  endtask

  task automatic test_overrun();
    cal_delay = 8'd10; tfc_in = W_CAL; tick(); tfc_in = '0; cal_delay = 8'd3;
    for (int j = 1; j <= 14; j++) begin
      tfc_in = (j == 3) ? W_CAL : 8'h00;
      checks++;
      if ({calib_pulse, calib_busy, calib_overrun} !== {1'(j == 11), 1'(j <= 11), 1'(j >= 4)}) begin
        errors++; $display("FAIL overrun[k+%0d]: pulse,busy,ovr=%b expected %b", j,
                           {calib_pulse, calib_busy, calib_overrun}, {1'(j == 11), 1'(j <= 11), 1'(j >= 4)});
      end
      tick();
    end
    tfc_in = '0; err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if (calib_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr: got %b expected 0", calib_overrun); end
  endtask

  task automatic test_back_to_back();
    cal_delay = 8'd2; tfc_in = W_CAL; tick(); tfc_in = '0;
    for (int j = 1; j <= 7; j++) begin
      tfc_in = (j == 3) ? W_CAL : 8'h00;
      cal_delay = (j == 3) ? 8'd1 : 8'd2;
      checks++;
      if ({calib_pulse, calib_busy, calib_overrun} !== {1'(j == 3 || j == 5), 1'(j <= 5), 1'b0}) begin
        errors++; $display("FAIL b2b[k+%0d]: pulse,busy,ovr=%b expected %b", j,
                           {calib_pulse, calib_busy, calib_overrun}, {1'(j == 3 || j == 5), 1'(j <= 5), 1'b0});
      end
      tick();
    end
    tfc_in = '0;
  endtask

  task automatic test_fe_reset();
    tfc_in = W_FER; tick(); tfc_in = '0;
    for (int j = 1; j <= 6; j++) begin
      checks++;
      if (fe_reset_o !== 1'(j <= 4)) begin
        errors++; $display("FAIL fe_len[k+%0d]: got %b expected %b", j, fe_reset_o, 1'(j <= 4));
      end
      tick();
    end
    tfc_in = W_FER; tick(); tfc_in = '0;
    for (int j = 1; j <= 8; j++) begin
      tfc_in = (j == 2) ? W_FER : 8'h00;
      checks++;
      if (fe_reset_o !== 1'(j <= 6)) begin
        errors++; $display("FAIL fe_retrig[k+%0d]: got %b expected %b", j, fe_reset_o, 1'(j <= 6));
      end
      tick();
    end
    tfc_in = '0;
  endtask

  task automatic test_fe_abort();
    cal_delay = 8'd10; tfc_in = W_CAL; tick(); tfc_in = '0;
    for (int j = 1; j <= 14; j++) begin
      tfc_in = (j == 3) ? W_FER : 8'h00;
      checks++;
      if ({calib_pulse, calib_busy} !== {1'b0, 1'(j <= 3)}) begin
        errors++; $display("FAIL fe_abort[k+%0d]: pulse,busy=%b expected %b", j,
                           {calib_pulse, calib_busy}, {1'b0, 1'(j <= 3)});
      end
      tick();
    end
    tfc_in = W_CAL; tick(); tfc_in = '0;
    for (int j = 1; j <= 14; j++) begin
      tfc_in = (j == 2) ? (W_FER | W_CAL) : 8'h00;
      checks++;
      if ({calib_pulse, calib_busy, calib_overrun} !== {1'b0, 1'(j <= 2), 1'b0}) begin
        errors++; $display("FAIL fe_cal_same[k+%0d]: pulse,busy,ovr=%b expected %b", j,
                           {calib_pulse, calib_busy, calib_overrun}, {1'b0, 1'(j <= 2), 1'b0});
      end
      tick();
    end
    tfc_in = '0;
  endtask

  task automatic test_reset_mid();
    tfc_in = W_FER; tick();
    tfc_in = W_CAL; cal_delay = 8'd10; tick(); tfc_in = '0;
    checks++;
    if ({fe_reset_o, calib_busy} !== 2'b11) begin
      errors++; $display("FAIL mid_pre: fe,busy=%b expected 11", {fe_reset_o, calib_busy});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bxid, strb, misc} !== 23'd0) begin
      errors++; $display("FAIL mid_async: bxid=%0d strb=%b misc=%b expected all 0", bxid, strb, misc);
    end
    tick(); rst_n = 1'b1;
    cal_delay = 8'd0; tfc_in = W_CAL; tick(); tfc_in = '0;
    checks++;
    if ({bxid, calib_pulse} !== {12'd1, 1'b1}) begin
      errors++; $display("FAIL mid_cal: bxid=%0d pulse=%b expected 1 1", bxid, calib_pulse);
    end
    tfc_in = W_BXR; tick();
    checks++;
    if ({bxid, sync_err} !== {12'd0, 1'b0}) begin
      errors++; $display("FAIL mid_first_bxr: bxid=%0d err=%b expected 0 0", bxid, sync_err);
    end
    tick(); tfc_in = '0;
    checks++;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL mid_second_bxr: got %b expected 1", sync_err); end
  endtask

  initial begin
    test_reset();
    test_bx_count();
    test_bx_sync();
    test_strobes();
    test_calib_d0();
    test_calib_d5();
    test_overrun();
    test_back_to_back();
    test_fe_reset();
    test_fe_abort();
    repeat (6) tick();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
